// File: rtl/input_conditioner.sv
// input_conditioner: front-end for board switches and push-buttons.
// Each raw input bit is brought into the clock domain through a two-flop
// synchronizer and then debounced on its own. The clean level S feeds the
// combinational gate network. RISE/FALL are one-cycle edge strobes, and
// CHANGED marks any edge in the same cycle.
//
// Optional build macro: INPUT_INVERT_EN
//   When defined, RAW is inverted ahead of the synchronizer so that
//   active-low buttons read as 1 when pressed. Reset values stay 0.
//
// Per-bit debounce behaviour:
//   STABLE  : sync2 == S, count held at 0
//   PENDING : sync2 != S, count advances once per cycle
// S takes the new value on the cycle where the count has already reached
// DEBOUNCE_CYCLES-1 and the difference is still present. This means the
// difference must be seen on DEBOUNCE_CYCLES consecutive edges. Any cycle
// in which sync2 matches S again sends the count back to 0.

module input_conditioner #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] RAW,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             CHANGED
);

    // The counter only has to hold 0 .. DEBOUNCE_CYCLES-1.
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

`ifdef INPUT_INVERT_EN
    assign raw_in = ~RAW;
`else
    assign raw_in = RAW;
`endif

    // Two-flop synchronizer. This is the only logic that reads the pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce decision: hold, keep counting, or accept the new level.
    always_comb begin
        s_next    = S;
        rise_next = '0;
        fall_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i];
            if (sync2[i] == S[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                s_next[i]    = sync2[i];
                cnt_next[i]  = '0;
                rise_next[i] = sync2[i];
                fall_next[i] = ~sync2[i];
            end else begin
                cnt_next[i] = cnt[i] + CNT_ONE;
            end
        end
    end

    // Register the clean levels, the counts and the edge strobes together,
    // so that CHANGED lines up exactly with RISE/FALL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            S       <= '0;
            RISE    <= '0;
            FALL    <= '0;
            CHANGED <= 1'b0;
            cnt     <= '{default: '0};
        end else begin
            S       <= s_next;
            RISE    <= rise_next;
            FALL    <= fall_next;
            CHANGED <= |(rise_next | fall_next);
            cnt     <= cnt_next;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: self-checking bench for input_conditioner.
// The reference model treats each bit as a stream of synchronized samples.
// A bit's clean level flips when the last DEBOUNCE_CYCLES samples all
// disagree with the current level. Stimulus is written as logical
// "active" levels, which makes the same sequences valid with or without
// INPUT_INVERT_EN.

module tb_input_conditioner;

    localparam int WIDTH = 5;
    localparam int DEB   = 4;

`ifdef INPUT_INVERT_EN
    localparam logic [WIDTH-1:0] INV_MASK = '1;
`else
    localparam logic [WIDTH-1:0] INV_MASK = '0;
`endif

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] RAW;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] RISE;
    logic [WIDTH-1:0] FALL;
    logic             CHANGED;

    int compare_count;
    int mismatch_count;

    // Reference model state.
    logic [WIDTH-1:0] pipe1_m;
    logic [WIDTH-1:0] pipe2_m;
    logic [WIDTH-1:0] win_m[$];
    logic [WIDTH-1:0] s_m;
    logic [WIDTH-1:0] rise_m;
    logic [WIDTH-1:0] fall_m;

    // Event tallies, used by the directed checks.
    int rise_seen[WIDTH];
    int fall_seen[WIDTH];
    int changed_seen;
    logic [WIDTH-1:0] rise_at_change;

    input_conditioner #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk    (clk),
        .reset  (reset),
        .RAW    (RAW),
        .S      (S),
        .RISE   (RISE),
        .FALL   (FALL),
        .CHANGED(CHANGED)
    );

    // 10 ns free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] active);
        RAW = active ^ INV_MASK;
    endtask

    task automatic model_reset();
        pipe1_m = '0;
        pipe2_m = '0;
        s_m     = '0;
        rise_m  = '0;
        fall_m  = '0;
        win_m   = {};
        for (int k = 0; k < DEB; k++) win_m.push_back('0);
    endtask

    // Pass one rising edge through the model. The synchronized sample seen
    // at this edge is the active level from two edges earlier.
    task automatic model_edge();
        logic [WIDTH-1:0] old_s;
        logic all_diff;
        old_s = s_m;
        win_m.push_back(pipe2_m);
        if (win_m.size() > DEB) void'(win_m.pop_front());
        for (int b = 0; b < WIDTH; b++) begin
            all_diff = 1'b1;
            foreach (win_m[k]) if (win_m[k][b] == old_s[b]) all_diff = 1'b0;
            if (all_diff) s_m[b] = ~old_s[b];
        end
        rise_m  = s_m & ~old_s;
        fall_m  = ~s_m & old_s;
        pipe2_m = pipe1_m;
        pipe1_m = RAW ^ INV_MASK;
    endtask

    task automatic clear_tallies();
        for (int b = 0; b < WIDTH; b++) begin
            rise_seen[b] = 0;
            fall_seen[b] = 0;
        end
        changed_seen   = 0;
        rise_at_change = '0;
    endtask

    // Advance one edge, update the model, then sample the DUT 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        checkOutput("S", 32'(S), 32'(s_m));
        checkOutput("RISE", 32'(RISE), 32'(rise_m));
        checkOutput("FALL", 32'(FALL), 32'(fall_m));
        checkOutput("CHANGED", 32'(CHANGED), 32'(|(rise_m | fall_m)));
        for (int b = 0; b < WIDTH; b++) begin
            if (RISE[b]) rise_seen[b]++;
            if (FALL[b]) fall_seen[b]++;
        end
        if (CHANGED) begin
            changed_seen++;
            rise_at_change = RISE;
        end
    endtask

    task automatic hold_reset_now();
        reset = 1'b1;
        model_reset();
        #1;
        checkOutput("rst_S", 32'(S), 32'(0));
        checkOutput("rst_pulses", 32'({RISE, FALL, CHANGED}), 32'(0));
    endtask

    // Count edges until S[b] goes to 1, giving up after 30 edges.
    task automatic edges_to_rise(input int b, output int n);
        n = -1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (n < 0 && S[b]) n = e;
        end
    endtask

    initial begin
        int n;
        int first;
        int pat[9];
        logic [WIDTH-1:0] act;

        compare_count  = 0;
        mismatch_count = 0;
        clear_tallies();
        applyStimulus('0);
        reset = 1'b1;
        model_reset();
        #12;
        checkOutput("rst_S", 32'(S), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Quiet inputs after reset: everything stays at 0.
        for (int c = 0; c < 20; c++) tick();
        checkOutput("idle_S", 32'(S), 32'(0));
        checkOutput("idle_changed", 32'(changed_seen), 32'(0));

        // Single rising input: expect 6-edge latency and one strobe.
        clear_tallies();
        applyStimulus(5'b00001);
        edges_to_rise(0, n);
        checkOutput("lat_b0", 32'(n), 32'(6));
        checkOutput("rise_b0", 32'(rise_seen[0]), 32'(1));
        checkOutput("chg_b0", 32'(changed_seen), 32'(1));
        applyStimulus('0);
        for (int c = 0; c < 10; c++) tick();

        // Glitch of 3 sampled edges is rejected.
        clear_tallies();
        applyStimulus(5'b00100);
        for (int c = 0; c < 3; c++) tick();
        applyStimulus('0);
        for (int c = 0; c < 12; c++) tick();
        checkOutput("glitch3_rise", 32'(rise_seen[2]), 32'(0));
        checkOutput("glitch3_S", 32'(S[2]), 32'(0));

        // A 4-edge excursion is accepted, and it later falls back.
        clear_tallies();
        applyStimulus(5'b00100);
        for (int c = 0; c < 4; c++) tick();
        applyStimulus('0);
        for (int c = 0; c < 14; c++) tick();
        checkOutput("pulse4_rise", 32'(rise_seen[2]), 32'(1));
        checkOutput("pulse4_fall", 32'(fall_seen[2]), 32'(1));

        // Bouncing input on bit 1. Only the final four 1s count.
        clear_tallies();
        pat = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
        first = -1;
        for (int k = 0; k < 17; k++) begin
            act = '0;
            act[1] = (k < 9) ? pat[k][0] : 1'b1;
            applyStimulus(act);
            tick();
            if (first < 0 && S[1]) first = k + 1;
        end
        checkOutput("bounce_edge", 32'(first), 32'(11));
        checkOutput("bounce_rise", 32'(rise_seen[1]), 32'(1));
        applyStimulus('0);
        for (int c = 0; c < 10; c++) tick();

        // Several bits change together and produce a single CHANGED pulse.
        clear_tallies();
        applyStimulus(5'b10101);
        for (int c = 0; c < 12; c++) tick();
        checkOutput("multi_S", 32'(S), 32'(5'b10101));
        checkOutput("multi_chg", 32'(changed_seen), 32'(1));
        checkOutput("multi_rise", 32'(rise_at_change), 32'(5'b10101));

        // Reset while bit 3 is pending (count = 2). The count is discarded.
        applyStimulus(5'b11101);
        for (int c = 0; c < 4; c++) tick();
        hold_reset_now();
        tick();
        tick();
        reset = 1'b0;
        clear_tallies();
        edges_to_rise(3, n);
        checkOutput("rst_pend_lat", 32'(n), 32'(6));
        checkOutput("rst_pend_rise", 32'(rise_seen[3]), 32'(1));
        checkOutput("rst_pend_S", 32'(S), 32'(5'b11101));

        // Randomized phase: slowly toggling bits, with occasional resets.
        act = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < WIDTH; b++)
                if ($urandom_range(0, 5) == 0) act[b] = ~act[b];
            applyStimulus(act);
            if ($urandom_range(0, 299) == 0) begin
                hold_reset_now();
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage for the board switches and push-buttons that drive the combinational gate network (2- to 5-input AND/OR gates).
- Synchronizes each raw input to the system clock and debounces it per bit.
- Presents clean levels (S) to the gate network, plus single-cycle rise/fall strobes for sequential consumers.
- All state is per bit; bits are fully independent.

Parameters:
- WIDTH, 5, number of conditioned inputs (matches widest gate fan-in).
- DEBOUNCE_CYCLES, 4, consecutive synchronized cycles a new value must hold before S changes. Legal range ≥1; board builds use 500000 at 50 MHz.
- Counter width is derived internally as ceil(log2(DEBOUNCE_CYCLES+1)) and is not a parameter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- RAW  input  WIDTH  unsynchronized switch/button levels.
- S  output  WIDTH  debounced level per bit; feeds the gate inputs.
- RISE  output  WIDTH  one-cycle pulse when S[i] goes 0→1.
- FALL  output  WIDTH  one-cycle pulse when S[i] goes 1→0.
- CHANGED  output  1  OR-reduction of RISE|FALL; registered in the same cycle as the pulses.

Behaviour:
- Reset (asynchronous assert, synchronous effect on release):
  - sync1, sync2, S, RISE, FALL, CHANGED and all counters go to 0 immediately on reset=1.
  - Held at 0 while reset is high.
- Synchronizer: two flops per bit (sync1<=RAW, sync2<=sync1); nothing else reads RAW.
- Per-bit debounce state machine, two states:
  - STABLE (sync2==S, cnt==0).
  - PENDING (sync2!=S).
- At each rising edge, per bit:
  - If sync2==S: cnt<=0; S holds; state STABLE.
  - If sync2!=S and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1; S holds; state PENDING.
  - If sync2!=S and cnt==DEBOUNCE_CYCLES-1: S<=sync2; cnt<=0; state STABLE.
- Pulses:
  - RISE[i]<=1 only at the edge where S[i] updates 0→1; FALL[i] likewise for 1→0; otherwise 0.
  - Pulses never last more than one cycle.
- Latency: S changes at the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge at which the new RAW value is sampled. The default gives 6 edges.
- Glitch rejection: a RAW excursion sampled on fewer than DEBOUNCE_CYCLES consecutive edges never reaches S. An excursion of exactly DEBOUNCE_CYCLES edges is accepted.
- Bounce during PENDING: any cycle with sync2==S clears cnt, and the full count restarts on the next difference.
- DEBOUNCE_CYCLES=1: S follows sync2 with one extra register stage (latency 3 edges).
- Simultaneous events:
  - Several bits may update in the same cycle; each asserts its own RISE/FALL, and CHANGED is a single pulse.
  - A bit cannot produce RISE and FALL in the same cycle.
- Reset mid-PENDING: the count is discarded. After release, an input still held high needs the full DEBOUNCE_CYCLES+2 edges, and produces RISE when S rises.
- The counter saturates logically at DEBOUNCE_CYCLES-1 and never wraps.

Optional Feature:
- Macro INPUT_INVERT_EN.
- When defined: RAW is inverted before sync1 (active-low board buttons). An idle pin at 1 yields S=0, and pressing (pin 0) yields S=1 and RISE. Reset values are unchanged (0).
- When undefined: RAW is used as-is.
- Ports, latency and pulse rules are identical in both builds.

Test Plan:
- Reset release with RAW=5'b00000 → S, RISE, FALL, CHANGED all 0 for 20 cycles.
- RAW[0] 0→1, held → S[0]=1 at the 6th edge after sampling; RISE[0] and CHANGED high for exactly that one cycle; other bits 0.
- RAW[2] high for 3 sampled edges then low → S[2] stays 0, no pulses. Repeat with 4 sampled edges → S[2]=1 then returns to 0, giving exactly one RISE[2] and one later FALL[2].
- RAW[1] bounce pattern 1,0,1,1,0,1,1,1,1 → S[1] rises only after the final 4 consecutive 1s; one RISE[1] total.
- RAW=5'b10101 applied in one cycle → S=5'b10101 on the same edge; RISE=5'b10101 for one cycle; a single CHANGED pulse.
- With RAW[3] held 1, assert reset mid-PENDING (cnt=2) for 2 cycles → S[3]=0 immediately. After release, S[3]=1 and RISE[3] at the 6th edge. With INPUT_INVERT_EN, RAW=5'b11111 idle → S=0; RAW[4]=0 → S[4]=1 after 6 edges.
